// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and watermark flow-control scheduler for a shared FIFO.
// Optional flag cross-check: define FIFO_WR_ARBITER_FLAG_CHECK_EN to build the sticky out_err logic.
module fifo_wr_arbiter #(
  parameter int ENTRIES = 4,
  parameter int N_REQ   = 4,
  parameter int HIGH_WM = 3,
  parameter int LOW_WM  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           in_req,
  input  logic                       in_rd_req,
  input  logic                       in_fifo_empty,
  input  logic                       in_fifo_full,
  output logic [N_REQ-1:0]           out_gnt,
  output logic                       out_fifo_write,
  output logic                       out_fifo_read,
  output logic [$clog2(ENTRIES):0]   out_count,
  output logic                       out_throttle,
  output logic                       out_err
);

  localparam int CW = $clog2(ENTRIES) + 1;
  localparam int PW = $clog2(N_REQ);

  typedef enum logic {
    FILL     = 1'b0,
    THROTTLE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           throttle_q;

  logic           eligible_s;
  logic           rd_s;
  logic           wr_s;
  logic           found_s;
  logic [PW-1:0]  gnt_idx_s;
  logic [N_REQ-1:0] gnt_s;
  int             idx_v;

  // A read in the same cycle never frees a slot for a write: eligibility looks only at count_q.
  assign eligible_s = rst_n & (state_q == FILL) & (count_q < CW'(ENTRIES)) & ~in_fifo_full;
  assign rd_s       = rst_n & in_rd_req & (count_q != {CW{1'b0}}) & ~in_fifo_empty;

  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = {PW{1'b0}};
    idx_v     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_v = (int'(rr_ptr_q) + i) % N_REQ;
      if (!found_s && in_req[idx_v]) begin
        found_s   = 1'b1;
        gnt_idx_s = PW'(idx_v);
      end else begin
        found_s   = found_s;
      end
    end
  end

  always_comb begin
    gnt_s = {N_REQ{1'b0}};
    if (eligible_s && found_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = {N_REQ{1'b0}};
    end
  end

  assign wr_s           = |gnt_s;
  assign out_gnt        = gnt_s;
  assign out_fifo_write = wr_s;
  assign out_fifo_read  = rd_s;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (wr_s) begin
      rr_ptr_d = (gnt_idx_s == PW'(N_REQ - 1)) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Hysteresis decisions use the post-update occupancy so throttling reacts in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (count_d >= CW'(HIGH_WM)) begin
          state_d = THROTTLE;
        end else begin
          state_d = FILL;
        end
      end
      THROTTLE: begin
        if (count_d <= CW'(LOW_WM)) begin
          state_d = FILL;
        end else begin
          state_d = THROTTLE;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      count_q    <= {CW{1'b0}};
      rr_ptr_q   <= {PW{1'b0}};
      throttle_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      throttle_q <= (state_d == THROTTLE);
    end
  end

  assign out_count    = count_q;
  assign out_throttle = throttle_q;

`ifdef FIFO_WR_ARBITER_FLAG_CHECK_EN
  logic mismatch_s;
  logic err_q;

  assign mismatch_s = (in_fifo_empty != (count_q == {CW{1'b0}})) |
                      (in_fifo_full  != (count_q == CW'(ENTRIES)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mismatch_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter and flow-control scheduler for the shared ENTRIES-deep FIFO.
- Shares the FIFO write port among N_REQ producers and gates the consumer read.
- Tracks occupancy and applies watermark hysteresis so producers back off before the FIFO fills.
- Drives the FIFO's write/read controls directly; the FIFO's empty/full flags feed back into it.

Parameters:
- ENTRIES, 4, FIFO depth.
- N_REQ, 4, number of write requesters; must be >= 2.
- HIGH_WM, 3, occupancy at which throttling starts.
- LOW_WM, 1, occupancy at which throttling ends.
- Constraint: 0 <= LOW_WM < HIGH_WM <= ENTRIES.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active low
- in_req  in  N_REQ  per-producer write request, level
- in_rd_req  in  1  consumer read request
- in_fifo_empty  in  1  FIFO empty flag
- in_fifo_full  in  1  FIFO full flag
- out_gnt  out  N_REQ  one-hot write grant, combinational
- out_fifo_write  out  1  FIFO write control, equals |out_gnt
- out_fifo_read  out  1  FIFO read control, combinational
- out_count  out  $clog2(ENTRIES)+1  registered occupancy
- out_throttle  out  1  registered; 1 = THROTTLE state
- out_err  out  1  sticky flag-mismatch error (see Optional Feature)

Behaviour:
- Reset (rst_n low at a rising edge):
  - count=0, rr_ptr=0, state=FILL, out_err=0.
  - While rst_n is low, out_gnt, out_fifo_write and out_fifo_read are forced to 0.
- Read path: out_fifo_read = in_rd_req & (count != 0) & ~in_fifo_empty. Zero latency.
- Write eligibility: state==FILL & count<ENTRIES & ~in_fifo_full.
  - A same-cycle read does not free a slot for a write when count==ENTRIES.
- Arbitration:
  - When eligible, grant the first set in_req bit searching upward from rr_ptr, wrapping N_REQ-1 -> 0. At most one grant bit set.
  - On a grant to index k: rr_ptr <= (k+1) mod N_REQ.
  - No grant: rr_ptr holds.
  - Requesters hold in_req until granted; a dropped request is simply not served.
- Count update:
  - +1 on write only; -1 on read only; unchanged on write and read together, or on neither.
  - Never wraps; the gating above guarantees 0..ENTRIES.
- State machine, using count_next (post-update value):
  - FILL -> THROTTLE when count_next >= HIGH_WM.
  - THROTTLE -> FILL when count_next <= LOW_WM.
  - Otherwise hold.
  - out_throttle is 1 in THROTTLE. No grants in THROTTLE; reads continue.
- Reset mid-operation: all state returns to reset values at the next edge. In-flight requests are re-arbitrated from index 0.

Optional Feature:
- Macro: FIFO_WR_ARBITER_FLAG_CHECK_EN.
- Defined: each cycle (out of reset), compare the FIFO's flags with the internal count.
  - Mismatch when in_fifo_empty != (count==0) or in_fifo_full != (count==ENTRIES).
  - On mismatch, set out_err on the next edge; it stays 1 until reset.
- Not defined: out_err is tied 0 and no compare logic is built.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_req=4'b1111, in_rd_req=1 -> out_gnt=0, out_fifo_read=0; after release, out_count=0, out_throttle=0.
- Round robin and throttle: in_req=4'b1111, no reads -> out_gnt=0001, 0010, 0100 on cycles 1-3 and out_count=1,2,3. out_throttle=1 after cycle 3; cycle 4 out_gnt=0.
- Hysteresis release: from count=3 in THROTTLE, in_rd_req=1 for 2 cycles -> out_count=2 then 1, out_throttle=0. With in_req=4'b1111, next out_gnt=1000 (rr_ptr=3).
- Simultaneous access: count=2, FILL, in_req=4'b0100, in_rd_req=1 -> out_fifo_write=1, out_fifo_read=1, out_count stays 2.
- Empty guard: count=0, in_rd_req=1 -> out_fifo_read=0, out_count=0. Full guard: in_fifo_full=1 with in_req set -> out_gnt=0.
- Flag check (macro defined): count=1, drive in_fifo_full=1 for 1 cycle -> out_err=1 next cycle and stays 1 after the flag drops, until rst_n=0.
